atanh_inv_search_4bit: RTL
==========================

ATANH_INV_SEARCH_4BIT -- requirements
Module: atanh_inv_search_4bit

Interface
REQ-001 Parameter: EARLY_EXIT, default 1, 1 = terminate search on first exact match, 0 = always evaluate all 16 candidates.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present; in_y is valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_y  input  4  target tanh code to invert.
REQ-007 out_valid  output  1  result present on out_x/out_err/out_exact.
REQ-008 out_ready  input  1  downstream accepts result.
REQ-009 out_x  output  4  recovered input code.
REQ-010 out_err  output  4  |F(out_x) - in_y|, unsigned.
REQ-011 out_exact  output  1  1 when out_err == 0.
REQ-012 busy  output  1  high in SEARCH state.

Function
REQ-013 Forward model F(x), x=0..15, SHALL be the fixed 4-bit approximate tanh table: 0,3,12,3,12,3,12,3,8,3,12,3,12,3,12,7.
REQ-014 Block SHALL return the x minimizing |F(x) - y|; on ties the smallest x wins.
REQ-015 FSM states: IDLE, SEARCH, DONE; only these three, encoded in registers.
REQ-016 IDLE: in_ready=1, out_valid=0, busy=0; on in_valid=1 at a clock edge, latch in_y, clear candidate counter to 0, best_err to 15, best_x to 0, go to SEARCH.
REQ-017 SEARCH: one candidate per cycle, counter c = 0..15 ascending; compute e = |F(c) - y| using 5-bit intermediate, result fits 4 bits.
REQ-018 SEARCH update: if e < best_err (strict) then best_err<=e, best_x<=c; equal error SHALL NOT replace the stored candidate.
REQ-019 SEARCH exit: go to DONE at the edge ending candidate c when c == 15, or when EARLY_EXIT=1 and e == 0.
REQ-020 Latency: with accept edge E0, out_valid rises at edge E0+c_last+1, where c_last is the last evaluated candidate (max E0+16).
REQ-021 SEARCH: in_ready=0, in_valid/in_y ignored; latched y unaffected by in_y changes.
REQ-022 DONE: out_valid=1, out_x/out_err/out_exact held stable until out_valid && out_ready at an edge, then go to IDLE.
REQ-023 No same-cycle turnaround: in_ready is low in DONE, so a new request is accepted no earlier than the cycle after the output handshake.
REQ-024 out_ready asserted while not in DONE SHALL have no effect.
REQ-025 Counter SHALL NOT wrap: counter never increments past 15; no extra evaluation cycle.
REQ-026 out_x/out_err/out_exact SHALL be registered; they hold last result values in IDLE and SEARCH (only qualified by out_valid).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, independent of clk.
REQ-028 Reset values: in_ready=1 (after FSM in IDLE), out_valid=0, busy=0, out_x=0, out_err=0, out_exact=0, internal y/counter/best_x=0, best_err=15.
REQ-029 Reset during SEARCH or DONE SHALL abandon the transaction; no out_valid pulse follows reset release.
REQ-030 First request may be accepted on the first rising edge with rst_n high.

Verification
REQ-031 EARLY_EXIT=1, in_y=12 -> out_valid at E0+3, out_x=2, out_err=0, out_exact=1; in_y=0 -> E0+1, out_x=0, exact.
REQ-032 EARLY_EXIT=1, in_y=8 -> out_x=8 at E0+9; in_y=7 -> out_x=15 at E0+16, out_err=0.
REQ-033 No exact match: in_y=5 -> out_x=1, out_err=2, out_exact=0 at E0+16 (tie with x=15 resolved to 1); in_y=15 -> out_x=2, out_err=3.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_y changes ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 Reset mid-search: assert rst_n=0 at E0+4 of in_y=7 request -> all outputs at reset values immediately, no result produced; next request in_y=3 -> out_x=1, exact.
REQ-036 EARLY_EXIT=0: in_y=12 -> out_valid at E0+16, out_x=2 (smallest exact, later matches not taken); exhaustive sweep of all 16 in_y matches a reference model of REQ-013/014.

Source files
------------

// File: rtl/atanh_inv_search_4bit.sv
// ---------------------------------------------------------------------------
// atanh_inv_search_4bit
//
// Inverts a fixed 4-bit approximate tanh table by sequential search. A request
// (in_y) is latched, then one candidate x = 0..15 is evaluated per clock. The
// block keeps the x with the smallest |F(x) - y|; the smallest x wins a tie.
// With EARLY_EXIT = 1 the search stops at the first exact match.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request present (in_y valid)
//   in_ready   : block idle and able to accept a request
//   in_y       : target tanh code
//   out_valid  : result present on out_x / out_err / out_exact
//   out_ready  : downstream accepts the result
//   out_x      : recovered input code
//   out_err    : |F(out_x) - y|
//   out_exact  : out_err == 0
//   busy       : search in progress
// ---------------------------------------------------------------------------
module atanh_inv_search_4bit #(
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_x,
    output logic [3:0] out_err,
    output logic       out_exact,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Forward model: the approximate tanh code for each input code.
    function automatic logic [3:0] fwd_f(input logic [3:0] x);
        logic [3:0] f;
        case (x)
            4'd0:    f = 4'd0;
            4'd1:    f = 4'd3;
            4'd2:    f = 4'd12;
            4'd3:    f = 4'd3;
            4'd4:    f = 4'd12;
            4'd5:    f = 4'd3;
            4'd6:    f = 4'd12;
            4'd7:    f = 4'd3;
            4'd8:    f = 4'd8;
            4'd9:    f = 4'd3;
            4'd10:   f = 4'd12;
            4'd11:   f = 4'd3;
            4'd12:   f = 4'd12;
            4'd13:   f = 4'd3;
            4'd14:   f = 4'd12;
            4'd15:   f = 4'd7;
            default: f = 4'd0;
        endcase
        return f;
    endfunction

    // Absolute difference of two 4-bit codes; the 5-bit intermediate keeps the
    // subtraction from wrapping, and the magnitude always fits back in 4 bits.
    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        if (a >= b) begin
            d = {1'b0, a} - {1'b0, b};
        end else begin
            d = {1'b0, b} - {1'b0, a};
        end
        return d[3:0];
    endfunction

    state_e     state_q, state_d;
    logic [3:0] y_q, y_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] best_x_q, best_x_d;
    logic [3:0] best_err_q, best_err_d;
    logic [3:0] out_x_q, out_x_d;
    logic [3:0] out_err_q, out_err_d;
    logic       out_exact_q, out_exact_d;

    logic [3:0] cand_err_s;
    logic       better_s;
    logic       last_s;
    logic [3:0] fin_x_s;
    logic [3:0] fin_err_s;

    // Error of the candidate under evaluation and the search-exit decision.
    always_comb begin
        cand_err_s = abs_diff(fwd_f(cnt_q), y_q);
        // Strict compare: an equal error never displaces an earlier candidate.
        better_s   = (cand_err_s < best_err_q);
        if (cnt_q == 4'd15) begin
            last_s = 1'b1;
        end else if ((EARLY_EXIT != 0) && (cand_err_s == 4'd0)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        if (better_s) begin
            fin_x_s   = cnt_q;
            fin_err_s = cand_err_s;
        end else begin
            fin_x_s   = best_x_q;
            fin_err_s = best_err_q;
        end
    end

    // Next-state and datapath update for the IDLE / SEARCH / DONE sequence.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        best_x_d    = best_x_q;
        best_err_d  = best_err_q;
        out_x_d     = out_x_q;
        out_err_d   = out_err_q;
        out_exact_d = out_exact_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    y_d        = in_y;
                    cnt_d      = 4'd0;
                    best_x_d   = 4'd0;
                    best_err_d = 4'd15;
                    state_d    = ST_SEARCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                best_x_d   = fin_x_s;
                best_err_d = fin_err_s;
                if (last_s) begin
                    // Result registers are loaded with the candidate just
                    // evaluated folded in; the counter stops here, no wrap.
                    out_x_d     = fin_x_s;
                    out_err_d   = fin_err_s;
                    out_exact_d = (fin_err_s == 4'd0);
                    state_d     = ST_DONE;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    state_d     = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= 4'd0;
            cnt_q       <= 4'd0;
            best_x_q    <= 4'd0;
            best_err_q  <= 4'd15;
            out_x_q     <= 4'd0;
            out_err_q   <= 4'd0;
            out_exact_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            best_x_q    <= best_x_d;
            best_err_q  <= best_err_d;
            out_x_q     <= out_x_d;
            out_err_q   <= out_err_d;
            out_exact_q <= out_exact_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_SEARCH);
        out_x     = out_x_q;
        out_err   = out_err_q;
        out_exact = out_exact_q;
    end

endmodule
